// File: rtl/switch_buffered_if.sv
// Ready/valid bundle between an upstream stage, the buffered switch and its downstream stages.
// The switch side connects through slave; the driving environment connects through master.
interface switch_buffered_if #(
  parameter int unsigned N_PORTS             = 4,
  parameter int unsigned DWIDTH              = 8,
  parameter int unsigned LATENCY_COUNT_WIDTH = 4
);
  logic [N_PORTS-1:0]                     in_valid;
  logic [N_PORTS*DWIDTH-1:0]              in_data;
  logic [N_PORTS-1:0]                     in_ready;
  logic [N_PORTS*LATENCY_COUNT_WIDTH-1:0] in_latency;
  logic [N_PORTS-1:0]                     out_valid;
  logic [N_PORTS*DWIDTH-1:0]              out_data;
  logic [N_PORTS-1:0]                     out_ready;
  logic [N_PORTS*LATENCY_COUNT_WIDTH-1:0] out_latency;

  modport slave (
    input  in_valid, in_data, out_ready, out_latency,
    output in_ready, in_latency, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready, out_latency,
    input  in_ready, in_latency, out_valid, out_data
  );
endinterface

// File: rtl/switch_buffered.sv
// N-port load-balancing switch: each valid input is steered to the cheapest free output FIFO,
// with round-robin input priority and a registered minimum-cost estimate fed back upstream.
module switch_buffered #(
  parameter int unsigned N_PORTS             = 4,
  parameter int unsigned DWIDTH              = 8,
  parameter int unsigned LATENCY_COUNT_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  switch_buffered_if.slave bus
);

  localparam int unsigned LW  = LATENCY_COUNT_WIDTH;
  localparam int unsigned OCW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned IW  = $clog2(N_PORTS);
  localparam int unsigned SW  = ((LW > OCW) ? LW : OCW) + 1;
  localparam logic [LW-1:0] LAT_MAX = {LW{1'b1}};

  logic [OCW-1:0]    occ_q    [N_PORTS];
  logic [OCW-1:0]    occ_d    [N_PORTS];
  logic [PW-1:0]     wr_ptr_q [N_PORTS];
  logic [PW-1:0]     wr_ptr_d [N_PORTS];
  logic [PW-1:0]     rd_ptr_q [N_PORTS];
  logic [PW-1:0]     rd_ptr_d [N_PORTS];
  logic [DWIDTH-1:0] mem_q    [N_PORTS][FIFO_DEPTH];
  logic [DWIDTH-1:0] mem_d    [N_PORTS][FIFO_DEPTH];
  logic [IW-1:0]     rr_q, rr_d;
  logic [LW-1:0]     lat_q, lat_d;

  logic [SW-1:0]     sum_c       [N_PORTS];
  logic [LW-1:0]     cost_c      [N_PORTS];
  logic [DWIDTH-1:0] push_data_c [N_PORTS];
  logic [N_PORTS-1:0] grant_c, push_c, pop_c, taken_c;
  int                idx_c, best_c;
  logic              found_c;

  // Saturating per-output cost: downstream latency plus local occupancy.
  always_comb begin
    for (int j = 0; j < N_PORTS; j++) begin
      sum_c[j]  = SW'(bus.out_latency[j*LW +: LW]) + SW'(occ_q[j]);
      cost_c[j] = (sum_c[j] > SW'(LAT_MAX)) ? LAT_MAX : LW'(sum_c[j]);
    end
  end

  // Greedy grant in round-robin order; each input claims the cheapest untaken non-full output.
  always_comb begin
    grant_c = '0;
    push_c  = '0;
    taken_c = '0;
    idx_c   = 0;
    best_c  = 0;
    found_c = 1'b0;
    for (int j = 0; j < N_PORTS; j++) push_data_c[j] = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx_c   = (int'(rr_q) + k) % int'(N_PORTS);
      found_c = 1'b0;
      best_c  = 0;
      if (rst_n && bus.in_valid[idx_c]) begin
        for (int j = 0; j < N_PORTS; j++) begin
          if ((occ_q[j] < OCW'(FIFO_DEPTH)) && !taken_c[j] &&
              (!found_c || (cost_c[j] < cost_c[best_c]))) begin
            found_c = 1'b1;
            best_c  = j;
          end
        end
        if (found_c) begin
          grant_c[idx_c]      = 1'b1;
          taken_c[best_c]     = 1'b1;
          push_c[best_c]      = 1'b1;
          push_data_c[best_c] = bus.in_data[idx_c*DWIDTH +: DWIDTH];
        end
      end
    end
  end

  // FIFO, round-robin and latency next state.
  always_comb begin
    mem_d = mem_q;
    rr_d  = rr_q;
    lat_d = LAT_MAX;
    pop_c = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      occ_d[j]    = occ_q[j];
      wr_ptr_d[j] = wr_ptr_q[j];
      rd_ptr_d[j] = rd_ptr_q[j];
      pop_c[j]    = (occ_q[j] != '0) && bus.out_ready[j];
      if (push_c[j]) begin
        mem_d[j][wr_ptr_q[j]] = push_data_c[j];
        wr_ptr_d[j]           = wr_ptr_q[j] + PW'(1);
      end
      if (pop_c[j]) rd_ptr_d[j] = rd_ptr_q[j] + PW'(1);
      if (push_c[j] && !pop_c[j]) occ_d[j] = occ_q[j] + OCW'(1);
      else if (!push_c[j] && pop_c[j]) occ_d[j] = occ_q[j] - OCW'(1);
      if (cost_c[j] < lat_d) lat_d = cost_c[j];
    end
    if (|(bus.in_valid & ~grant_c)) begin
      rr_d = (rr_q == IW'(N_PORTS - 1)) ? '0 : rr_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N_PORTS; j++) begin
        occ_q[j]    <= '0;
        wr_ptr_q[j] <= '0;
        rd_ptr_q[j] <= '0;
      end
      rr_q  <= '0;
      lat_q <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rr_q     <= rr_d;
      lat_q    <= lat_d;
    end
  end

  // Storage needs no reset: occupancy gates everything visible downstream.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.in_ready   = grant_c;
  assign bus.in_latency = {N_PORTS{lat_q}};

  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      bus.out_valid[j]                  = (occ_q[j] != '0);
      bus.out_data[j*DWIDTH +: DWIDTH]  = mem_q[j][rd_ptr_q[j]];
    end
  end

endmodule

// File: tb/tb_switch_buffered.sv
// Directed bench for switch_buffered with a per-output scoreboard and a cost/grant reference model.
module tb_switch_buffered;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 4;
  localparam int unsigned D  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_buffered_if #(.N_PORTS(N), .DWIDTH(DW), .LATENCY_COUNT_WIDTH(LW)) bus ();

  switch_buffered #(
    .N_PORTS(N), .DWIDTH(DW), .LATENCY_COUNT_WIDTH(LW), .FIFO_DEPTH(D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  sbq [4][$];
  logic [7:0]  out0_log [$];
  int          m_p = 0;
  int          m_lat = 0;
  logic [3:0]  obs_ready, obs_ov;
  logic [31:0] obs_od;
  logic [15:0] obs_lat;
  logic        log_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, compare against the model, advance the model, then cross one edge.
  task automatic step();
    int cost[4];
    int tgt[4];
    int best;
    int i;
    int minc;
    logic [3:0] er, taken;
    #2;
    obs_ready = bus.in_ready;
    obs_ov    = bus.out_valid;
    obs_od    = bus.out_data;
    obs_lat   = bus.in_latency;
    for (int j = 0; j < 4; j++) begin
      cost[j] = int'(bus.out_latency[j*4 +: 4]) + sbq[j].size();
      if (cost[j] > 15) cost[j] = 15;
      tgt[j] = -1;
    end
    er = '0;
    taken = '0;
    for (int k = 0; k < 4; k++) begin
      i = (m_p + k) % 4;
      if (bus.in_valid[i]) begin
        best = -1;
        for (int j = 0; j < 4; j++)
          if (sbq[j].size() < 4 && !taken[j] && (best < 0 || cost[j] < cost[best])) best = j;
        if (best >= 0) begin
          er[i] = 1'b1;
          taken[best] = 1'b1;
          tgt[i] = best;
        end
      end
    end
    chk("in_ready", 32'(obs_ready), 32'(er));
    chk("in_latency", 32'(obs_lat), 32'({4{4'(m_lat)}}));
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("out_valid%0d", j), 32'(obs_ov[j]), 32'(sbq[j].size() != 0));
      if (sbq[j].size() != 0)
        chk($sformatf("out_data%0d", j), 32'(obs_od[j*8 +: 8]), 32'(sbq[j][0]));
    end
    for (int j = 0; j < 4; j++) begin
      if (sbq[j].size() != 0 && bus.out_ready[j]) begin
        if (log_en && j == 0) out0_log.push_back(obs_od[7:0]);
        void'(sbq[j].pop_front());
      end
    end
    for (int k = 0; k < 4; k++)
      if (tgt[k] >= 0) sbq[tgt[k]].push_back(bus.in_data[k*8 +: 8]);
    if (|(bus.in_valid & ~er)) m_p = (m_p + 1) % 4;
    minc = 15;
    for (int j = 0; j < 4; j++) if (cost[j] < minc) minc = cost[j];
    m_lat = minc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int cyc;
    logic tog;
    bus.in_valid    = '1;
    bus.in_data     = '0;
    bus.out_ready   = '0;
    bus.out_latency = '0;

    // Reset holds everything quiet even with inputs asserted.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_in_latency", 32'(bus.in_latency), 32'h0);
    bus.in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Tie-break to output 0 when all costs are equal.
    bus.in_valid = 4'b0001;
    bus.in_data  = 32'h0000_00A5;
    step();
    chk("tiebreak_ready", 32'(obs_ready), 32'h1);
    bus.in_valid = '0;
    step();
    chk("tiebreak_valid", 32'(obs_ov), 32'h1);
    chk("tiebreak_data", 32'(obs_od[7:0]), 32'hA5);
    bus.out_ready = '1;
    step();
    bus.out_ready = '0;

    // Cost steering with out_latency j0..j3 = 3,1,2,5.
    bus.out_latency = 16'h5213;
    bus.in_valid    = 4'b0101;
    bus.in_data     = 32'h0022_0011;
    step();
    chk("steer_ready", 32'(obs_ready), 32'h5);
    bus.in_valid = '0;
    step();
    chk("steer_valid", 32'(obs_ov), 32'h6);
    chk("steer_out1", 32'(obs_od[15:8]), 32'h11);
    chk("steer_out2", 32'(obs_od[23:16]), 32'h22);
    bus.out_ready = '1;
    step();
    bus.out_ready = '0;

    // Latency feedback: occ[0]=3 with out_latency[0]=2, then saturation.
    bus.out_latency = 16'h9992;
    bus.in_valid    = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      bus.in_data = 32'(8'h30 + k);
      step();
    end
    bus.in_valid = '0;
    step();
    step();
    chk("lat_fb", 32'(obs_lat), 32'h5555);
    bus.out_latency = 16'hFFFF;
    step();
    step();
    chk("lat_sat", 32'(obs_lat), 32'hFFFF);
    bus.out_ready = '1;
    repeat (3) step();
    bus.out_ready = '0;

    // Fill outputs 1..3 while output 0 is made expensive.
    bus.out_latency = 16'h000F;
    bus.in_valid    = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      bus.in_data = 32'(8'h40 + k);
      step();
    end

    // Fairness: only output 0 drains, so grants rotate across inputs.
    bus.out_ready = 4'b0001;
    bus.in_valid  = 4'b1111;
    bus.in_data   = 32'hD3C2_B1A0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("fair_grant%0d", k), 32'(obs_ready), 32'(4'b0001 << (k % 4)));
    end
    bus.in_valid = '0;
    step();

    // Wrap and ordering through output 0 with a toggling out_ready.
    log_en = 1'b1;
    sent = 0;
    cyc  = 0;
    tog  = 1'b1;
    while ((sent < 10 || sbq[0].size() != 0) && cyc < 80) begin
      bus.in_valid  = (sent < 10) ? 4'b0001 : 4'b0000;
      bus.in_data   = 32'(sent + 1);
      bus.out_ready = {3'b000, tog};
      step();
      if (obs_ready[0]) sent++;
      tog = ~tog;
      cyc++;
    end
    log_en = 1'b0;
    chk("wrap_sent", 32'(sent), 32'd10);
    chk("wrap_count", 32'(out0_log.size()), 32'd10);
    for (int k = 0; k < 10; k++)
      if (k < out0_log.size()) chk($sformatf("wrap_data%0d", k), 32'(out0_log[k]), 32'(k + 1));

    // Asynchronous reset mid-cycle while outputs 1..3 still hold data.
    bus.in_valid  = 4'b1111;
    bus.out_ready = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst2_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst2_in_latency", 32'(bus.in_latency), 32'h0);
    for (int j = 0; j < 4; j++) sbq[j].delete();
    m_p   = 0;
    m_lat = 0;
    bus.in_valid    = '0;
    bus.out_latency = 16'h9647;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("rst_release_lat", 32'(obs_lat), 32'h4444);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
